// File: rtl/regfile_sched_pkg.sv
// Shared definitions for the register-file write scheduler.
//   NUM_REGS : number of architectural registers tracked by the scoreboard
//   REG_ZERO : hard-wired zero register; never written, never busy
//   src_t    : which writeback port owns a grant or an output-stage entry
package regfile_sched_pkg;

    localparam int         NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SRC_A = 1'b0,   // single-cycle ALU writeback
        SRC_B = 1'b1    // long-latency mult/div/load writeback
    } src_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Bus bundle between the execute/writeback units and the write scheduler.
//   issue_*        : long-latency issue request and its acceptance
//   ReadRegister*  : decoded source addresses, hazard*: RAW stall flags
//   a_*, b_*       : writeback requests from the ALU (A) and long-latency unit (B)
//   RegWrite/WriteRegister/WriteData : registered register-file write port
// master: the surrounding pipeline (drives requests, sees grants/flags).
// slave : the scheduler itself.
interface regfile_write_scheduler_if #(
    parameter int N = 32
);
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready;
    logic [4:0]   ReadRegister1;
    logic [4:0]   ReadRegister2;
    logic         hazard1;
    logic         hazard2;
    logic         a_valid;
    logic [4:0]   a_reg;
    logic [N-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [4:0]   b_reg;
    logic [N-1:0] b_data;
    logic         b_ready;
    logic         RegWrite;
    logic [4:0]   WriteRegister;
    logic [N-1:0] WriteData;

    modport master (
        output issue_valid, issue_rd, ReadRegister1, ReadRegister2,
               a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  issue_ready, hazard1, hazard2, a_ready, b_ready,
               RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  issue_valid, issue_rd, ReadRegister1, ReadRegister2,
               a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output issue_ready, hazard1, hazard2, a_ready, b_ready,
               RegWrite, WriteRegister, WriteData
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for registers with an outstanding long-latency result.
//   clk, reset       : clock, asynchronous active-low reset
//   issue_valid/rd   : issuing long-latency op; issue_ready accepts it
//   rd_addr1/2       : source addresses; hazard1/2 flag pending writes
//   wr_en/wr_reg     : current output-stage write (RegWrite/WriteRegister)
//   wr_src_b         : output-stage entry came from the long-latency port
module regfile_scoreboard
    import regfile_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    output logic       issue_ready,
    input  logic [4:0] rd_addr1,
    input  logic [4:0] rd_addr2,
    output logic       hazard1,
    output logic       hazard2,
    input  logic       wr_en,
    input  logic [4:0] wr_reg,
    input  logic       wr_src_b
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // A read also hazards on the write sitting in the output stage: the
    // register file only captures it on the coming edge.
    function automatic logic pending(input logic [4:0] addr,
                                     input logic [NUM_REGS-1:0] bv,
                                     input logic we,
                                     input logic [4:0] wa);
        return (addr != REG_ZERO) && (bv[addr] || (we && (wa == addr)));
    endfunction

    assign issue_ready = ~busy[issue_rd] | (issue_rd == REG_ZERO);
    assign hazard1     = pending(rd_addr1, busy, wr_en, wr_reg);
    assign hazard2     = pending(rd_addr2, busy, wr_en, wr_reg);

    // Clear is applied before set so a new issue to the register being
    // retired this edge leaves it busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready && (issue_rd != REG_ZERO))
            set_mask[issue_rd] = 1'b1;
        if (wr_en && wr_src_b)
            clr_mask[wr_reg] = 1'b1;
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= busy_next;
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between the ALU (port A) and the
// long-latency unit (port B), and tracks outstanding port-B destinations.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of regfile_write_scheduler_if (requests, grants,
//           hazard flags and the registered register-file write port)
//
// Handshake: a source raises x_valid with x_reg/x_data and holds them
// unchanged until it sees x_ready high in the same cycle; that cycle is the
// transfer. x_ready is combinational from the valids and round-robin state,
// at most one ready is high, and nothing is buffered here.
module regfile_write_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    regfile_write_scheduler_if.slave   bus
);

    src_t         rr_last;
    logic         grant_a;
    logic         grant_b;
    logic [4:0]   win_reg;
    logic [N-1:0] win_data;
    logic         win_write;

    logic         reg_write_q;
    logic [4:0]   wr_reg_q;
    logic [N-1:0] wr_data_q;
    logic         src_b_q;

    // On a conflict the port that did not win last time goes first.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            grant_a = (rr_last == SRC_B);
            grant_b = (rr_last == SRC_A);
        end else begin
            grant_a = bus.a_valid;
            grant_b = bus.b_valid;
        end
    end

    assign win_reg  = grant_b ? bus.b_reg  : bus.a_reg;
    assign win_data = grant_b ? bus.b_data : bus.a_data;
    // A grant to register 0 is consumed but never reaches the register file.
    assign win_write = (grant_a || grant_b) && (win_reg != REG_ZERO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last     <= SRC_B;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            src_b_q     <= 1'b0;
        end else begin
            if (grant_a)      rr_last <= SRC_A;
            else if (grant_b) rr_last <= SRC_B;
            reg_write_q <= win_write;
            src_b_q     <= win_write && grant_b;
            if (win_write) begin
                wr_reg_q  <= win_reg;
                wr_data_q <= win_data;
            end
        end
    end

    assign bus.a_ready       = grant_a;
    assign bus.b_ready       = grant_b;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = wr_reg_q;
    assign bus.WriteData     = wr_data_q;

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .rd_addr1    (bus.ReadRegister1),
        .rd_addr2    (bus.ReadRegister2),
        .hazard1     (bus.hazard1),
        .hazard2     (bus.hazard2),
        .wr_en       (reg_write_q),
        .wr_reg      (wr_reg_q),
        .wr_src_b    (src_b_q)
    );

endmodule
